// File: rtl/bp_pkg.sv
// Shared constants and helpers for the BTB branch predictor: counter init values
// and PC index/tag extraction, also used by the pipeline registers.
package bp_pkg;

  // Widest PC the helpers accept; callers zero-extend and truncate.
  localparam int unsigned BP_PC_W = 64;

  // Weakly not-taken: 2^(cnt_w-1)-1 (CNT_WNT).
  function automatic logic [3:0] cnt_wnt(input int unsigned cnt_w);
    return 4'((1 << (cnt_w - 1)) - 1);
  endfunction

  // Weakly taken: 2^(cnt_w-1) (CNT_WT).
  function automatic logic [3:0] cnt_wt(input int unsigned cnt_w);
    return 4'(1 << (cnt_w - 1));
  endfunction

  // Index is pc[idx_w+1:2]; pc[1:0] never participates.
  function automatic logic [BP_PC_W-1:0] pc_index(input logic [BP_PC_W-1:0] pc,
                                                  input int unsigned idx_w);
    return (pc >> 2) & ((BP_PC_W'(1) << idx_w) - BP_PC_W'(1));
  endfunction

  function automatic logic [BP_PC_W-1:0] pc_tag(input logic [BP_PC_W-1:0] pc,
                                                input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// N-bit saturating up/down counter with a parallel load, one per BTB entry.
// With CNT_W=1 it degenerates to a last-outcome bit.
module bp_sat_counter #(
  parameter int unsigned     CNT_W   = 2,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up) begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating counters, combinational DE lookup,
// EX update and mispredict/redirect. `BP_STATS_EN adds lookup/branch/mispredict counters.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_hit,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            stall,
  input  logic            flush,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

  localparam logic [CNT_W-1:0] CntRst   = CNT_W'(cnt_wnt(CNT_W));
  localparam logic [CNT_W-1:0] CntAlloc = CNT_W'(cnt_wt(CNT_W));

  logic [ENTRIES-1:0]              valid_q;
  logic [TAG_W-1:0]                tag_q    [ENTRIES];
  logic [XLEN-1:0]                 target_q [ENTRIES];
  logic [ENTRIES-1:0][CNT_W-1:0]   cnt;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit, commit, alloc, tgt_we;

  assign lk_idx  = IDX_W'(pc_index(BP_PC_W'(lk_pc), IDX_W));
  assign lk_tag  = TAG_W'(pc_tag(BP_PC_W'(lk_pc), IDX_W));
  assign upd_idx = IDX_W'(pc_index(BP_PC_W'(upd_pc), IDX_W));
  assign upd_tag = TAG_W'(pc_tag(BP_PC_W'(upd_pc), IDX_W));

  // Lookup reads pre-edge state only; no bypass from a same-cycle update.
  always_comb begin
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && cnt[lk_idx][CNT_W-1];
    lk_target = lk_hit ? target_q[lk_idx] : '0;
  end

  // Flush drops any same-cycle update.
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign commit  = upd_en && !stall && !flush;
  assign alloc   = commit && !upd_hit && upd_taken;
  assign tgt_we  = commit && upd_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      if (alloc)  tag_q[upd_idx]    <= upd_tag;
      if (tgt_we) target_q[upd_idx] <= upd_target;
    end
  end

  for (genvar i = 0; i < int'(ENTRIES); i++) begin : g_cnt
    logic sel;
    assign sel = commit && (upd_idx == IDX_W'(i));

    bp_sat_counter #(
      .CNT_W   (CNT_W),
      .RST_VAL (CntRst)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (sel && upd_hit),
      .up       (upd_taken),
      .load     (sel && !upd_hit && upd_taken),
      .load_val (CntAlloc),
      .cnt      (cnt[i])
    );
  end

  // Combinational so the PC mux sees the redirect in the same EX cycle.
  always_comb begin
    mispredict  = upd_en && !stall &&
                  ((upd_pred_taken != upd_taken) ||
                   (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
  end

`ifdef BP_STATS_EN
  logic [31:0] lookups_q, branches_q, mispred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookups_q  <= '0;
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (lk_hit && !stall) lookups_q  <= lookups_q + 32'd1;
      if (commit)           branches_q <= branches_q + 32'd1;
      if (mispredict)       mispred_q  <= mispred_q + 32'd1;
    end
  end

  assign stat_lookups  = lookups_q;
  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: a behavioural BTB model checked every cycle plus
// directed scenarios with literal expectations.
module tb_branch_predictor_btb;

  localparam int unsigned NENT = 16;
  localparam int          CMAX = 3;   // 2-bit counter ceiling
  localparam int          CNT_NT_INIT = 1;
  localparam int          CNT_T_INIT  = 2;

  logic        clk, rst_n;
  logic [31:0] lk_pc, lk_target;
  logic        lk_hit, lk_taken;
  logic        stall, flush, upd_en, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups, stat_branches, stat_mispred;
`endif

  branch_predictor_btb #(
    .XLEN    (32),
    .ENTRIES (16),
    .CNT_W   (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lk_pc           (lk_pc),
    .lk_hit          (lk_hit),
    .lk_taken        (lk_taken),
    .lk_target       (lk_target),
    .stall           (stall),
    .flush           (flush),
    .upd_en          (upd_en),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_branches   (stat_branches),
    .stat_mispred    (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each slot remembers which 64-byte-aligned owner region last allocated it.
  bit          m_valid [NENT];
  int unsigned m_owner [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_cnt   [NENT];
  int unsigned s_lk, s_br, s_mp;

  function automatic int unsigned slot(input logic [31:0] pc);
    return (pc / 4) % NENT;
  endfunction

  function automatic int unsigned owner(input logic [31:0] pc);
    return pc / (4 * NENT);
  endfunction

  function automatic bit e_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_owner[slot(pc)] == owner(pc));
  endfunction

  function automatic bit e_taken(input logic [31:0] pc);
    return e_hit(pc) && (m_cnt[slot(pc)] >= CNT_T_INIT);
  endfunction

  function automatic logic [31:0] e_target(input logic [31:0] pc);
    return e_hit(pc) ? m_tgt[slot(pc)] : 32'h0;
  endfunction

  function automatic bit e_mis();
    return upd_en && !stall &&
           ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target));
  endfunction

  function automatic logic [31:0] e_redirect();
    logic [31:0] seq;
    seq = upd_pc + 32'd4;
    return upd_taken ? upd_target : seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = '0; m_cnt[i] = CNT_NT_INIT;
      end
      s_lk = 0; s_br = 0; s_mp = 0;
    end else begin
      if (e_hit(lk_pc) && !stall) s_lk++;
      if (upd_en && !stall && !flush) s_br++;
      if (e_mis()) s_mp++;
      if (flush) begin
        for (int i = 0; i < NENT; i++) m_valid[i] = 0;
      end else if (upd_en && !stall) begin
        if (e_hit(upd_pc)) begin
          if (upd_taken) begin
            m_cnt[slot(upd_pc)] = (m_cnt[slot(upd_pc)] < CMAX) ? m_cnt[slot(upd_pc)] + 1 : CMAX;
            m_tgt[slot(upd_pc)] = upd_target;
          end else begin
            m_cnt[slot(upd_pc)] = (m_cnt[slot(upd_pc)] > 0) ? m_cnt[slot(upd_pc)] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[slot(upd_pc)] = 1;
          m_owner[slot(upd_pc)] = owner(upd_pc);
          m_tgt[slot(upd_pc)]   = upd_target;
          m_cnt[slot(upd_pc)]   = CNT_T_INIT;
        end
      end
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_lk_hit", 32'(lk_hit), 32'(e_hit(lk_pc)));
      chk("cyc_lk_taken", 32'(lk_taken), 32'(e_taken(lk_pc)));
      chk("cyc_lk_target", lk_target, e_target(lk_pc));
      chk("cyc_mispredict", 32'(mispredict), 32'(e_mis()));
      chk("cyc_redirect_pc", redirect_pc, e_redirect());
`ifdef BP_STATS_EN
      chk("cyc_stat_lookups", stat_lookups, s_lk);
      chk("cyc_stat_branches", stat_branches, s_br);
      chk("cyc_stat_mispred", stat_mispred, s_mp);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    set_upd(pc, tk, tgt);
    tick();
    upd_en = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lk_pc = pc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; upd_en = 0; upd_taken = 0;
    upd_pc = '0; upd_target = '0; upd_pred_taken = 0; upd_pred_target = '0;
    lk_pc = 32'h100;
    tick(); tick();
    rst_n = 1'b1;
    cmp_on = 1;
    tick();

    look(32'h100);
    chk("rst_hit", 32'(lk_hit), 32'd0);
    chk("rst_taken", 32'(lk_taken), 32'd0);
    chk("rst_target", lk_target, 32'h0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);

    // Allocate 0x100 -> 0x80; the not-predicted taken branch redirects.
    set_upd(32'h100, 1'b1, 32'h80);
    #1;
    chk("alloc_mispredict", 32'(mispredict), 32'd1);
    chk("alloc_redirect", redirect_pc, 32'h80);
    tick();
    upd_en = 1'b0;
    look(32'h100);
    chk("alloc_hit", 32'(lk_hit), 32'd1);
    chk("alloc_taken", 32'(lk_taken), 32'd1);
    chk("alloc_target", lk_target, 32'h80);
    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    chk("nt_once_taken", 32'(lk_taken), 32'd0);
    chk("nt_once_target", lk_target, 32'h80);

    // Saturation on 0x200 (shares slot 0 with 0x100).
    for (int i = 0; i < 5; i++) upd(32'h200, 1'b1, 32'h240);
    upd(32'h200, 1'b0, 32'h0);
    look(32'h200);
    chk("sat_hi_taken", 32'(lk_taken), 32'd1);
    for (int i = 0; i < 3; i++) upd(32'h200, 1'b0, 32'h0);
    look(32'h200);
    chk("sat_lo_taken", 32'(lk_taken), 32'd0);
    upd(32'h200, 1'b0, 32'h0);
    upd(32'h200, 1'b1, 32'h240);
    look(32'h200);
    chk("sat_floor_hit", 32'(lk_hit), 32'd1);
    chk("sat_floor_taken", 32'(lk_taken), 32'd0);

    // Alias: 0x140 evicts 0x100 from the same slot.
    upd(32'h100, 1'b1, 32'h90);
    look(32'h100);
    chk("alias_first_hit", 32'(lk_hit), 32'd1);
    upd(32'h140, 1'b1, 32'hA0);
    look(32'h100);
    chk("alias_old_miss", 32'(lk_hit), 32'd0);
    look(32'h140);
    chk("alias_new_hit", 32'(lk_hit), 32'd1);
    chk("alias_new_target", lk_target, 32'hA0);

    // Mispredict: wrong target, first stalled then live.
    set_upd(32'h304, 1'b1, 32'h84);
    upd_pred_taken = 1'b1; upd_pred_target = 32'h80; stall = 1'b1;
    #1;
    chk("stall_mispredict", 32'(mispredict), 32'd0);
    tick();
    look(32'h304);
    chk("stall_no_alloc", 32'(lk_hit), 32'd0);
    stall = 1'b0;
    #1;
    chk("tgt_mispredict", 32'(mispredict), 32'd1);
    chk("tgt_redirect", redirect_pc, 32'h84);
    tick();
    upd_en = 1'b0;
    look(32'h304);
    chk("tgt_alloc_target", lk_target, 32'h84);

    set_upd(32'h100, 1'b0, 32'h0);
    upd_pred_taken = 1'b1; upd_pred_target = 32'h80;
    #1;
    chk("nt_mispredict", 32'(mispredict), 32'd1);
    chk("nt_redirect", redirect_pc, 32'h104);
    upd_pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap_redirect", redirect_pc, 32'h0);
    upd_pred_taken = 1'b0;
    #1;
    chk("correct_nt_mispredict", 32'(mispredict), 32'd0);
    tick();
    upd_en = 1'b0;

    // Stalled update leaves state alone.
    set_upd(32'h500, 1'b1, 32'h20);
    stall = 1'b1;
    tick();
    stall = 1'b0; upd_en = 1'b0;
    look(32'h500);
    chk("stall_upd_miss", 32'(lk_hit), 32'd0);

    // Mixed traffic checked only by the model.
    for (int i = 0; i < 40; i++) begin
      upd_en          = 1'b1;
      upd_pc          = (i * 52) & 32'h3FC;
      upd_taken       = (i % 3) != 0;
      upd_target      = upd_pc + 32'h40 * i;
      upd_pred_taken  = (i % 2) != 0;
      upd_pred_target = upd_target ^ ((i % 4 == 0) ? 32'h4 : 32'h0);
      lk_pc           = ((i + 5) * 52) & 32'h3FC;
      stall           = (i % 7) == 3;
      tick();
    end
    upd_en = 1'b0; stall = 1'b0;

    // Flush drops the same-cycle update and invalidates everything.
    upd(32'h140, 1'b1, 32'hA0);
    set_upd(32'h600, 1'b1, 32'h30);
    flush = 1'b1;
    tick();
    flush = 1'b0; upd_en = 1'b0;
    look(32'h600);
    chk("flush_upd_dropped", 32'(lk_hit), 32'd0);
    look(32'h140);
    chk("flush_old_miss", 32'(lk_hit), 32'd0);

    // Asynchronous reset mid-cycle.
    upd(32'h700, 1'b1, 32'h10);
    look(32'h700);
    chk("pre_rst_hit", 32'(lk_hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hit", 32'(lk_hit), 32'd0);
    chk("async_rst_target", lk_target, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    look(32'h700);
    chk("post_rst_hit", 32'(lk_hit), 32'd0);
    tick();

    cmp_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
